// File: rtl/conv_layer_2_window_buf.sv
// 3x3 sliding-window generator over an 8-channel binary raster stream.
// Two per-channel line buffers supply the upper rows; outputs are registered.
module conv_layer_2_window_buf #(
  parameter int WIDTH  = 13,
  parameter int HEIGHT = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [7:0]  pixel_in,
  output logic [71:0] window_out,
  output logic        valid_out,
  output logic        frame_done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic [7:0][WIDTH-1:0]     lb0_q, lb0_d;   // row-2 per channel
  logic [7:0][WIDTH-1:0]     lb1_q, lb1_d;   // row-1 per channel
  logic [7:0][8:0]           win_q, win_d;
  logic [71:0]               wout_q, wout_d;
  logic                      vout_q, vout_d;
  logic                      fdone_q, fdone_d;
  logic                      last_col, last_row;

  assign last_col = (col_q == CW'(WIDTH - 1));
  assign last_row = (row_q == RW'(HEIGHT - 1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    lb0_d   = lb0_q;
    lb1_d   = lb1_q;
    win_d   = win_q;
    wout_d  = wout_q;
    vout_d  = 1'b0;
    fdone_d = 1'b0;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Each window row shifts left; the new column is {row-2, row-1, current}.
      for (int unsigned c = 0; c < 8; c++) begin
        win_d[c] = {pixel_in[c],        win_q[c][8:7],
                    lb1_q[c][col_q],    win_q[c][5:4],
                    lb0_q[c][col_q],    win_q[c][2:1]};
        lb0_d[c][col_q] = lb1_q[c][col_q];
        lb1_d[c][col_q] = pixel_in[c];
      end
      if (row_q >= RW'(2) && col_q >= CW'(2)) begin
        vout_d  = 1'b1;
        wout_d  = win_d;
        fdone_d = last_col && last_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      lb0_q   <= '0;
      lb1_q   <= '0;
      win_q   <= '0;
      wout_q  <= '0;
      vout_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      lb0_q   <= lb0_d;
      lb1_q   <= lb1_d;
      win_q   <= win_d;
      wout_q  <= wout_d;
      vout_q  <= vout_d;
      fdone_q <= fdone_d;
    end
  end

  assign window_out = wout_q;
  assign valid_out  = vout_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_conv_layer_2_window_buf.sv
// Scoreboard bench: the driver builds expected windows from a full frame image,
// the monitor pops and compares whenever valid_out is seen.
module tb_conv_layer_2_window_buf;

  localparam int W = 13;
  localparam int H = 13;

  typedef struct packed {
    logic [71:0] w;
    logic        fd;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic [71:0] window_out;
  logic        valid_out;
  logic        frame_done;

  conv_layer_2_window_buf #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .pixel_in   (pixel_in),
    .window_out (window_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic last_acc = 1'b0;
  logic last_rst = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_acc <= valid_in & ~rst;
    last_rst <= rst;
  end

  int checks = 0;
  int fails  = 0;
  int nvalid = 0;
  int nfd    = 0;
  exp_t        sbq[$];
  logic [71:0] got_q[$];
  logic [71:0] ref_q[$];
  logic [71:0] last_win = '0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (last_rst) begin
      chk("reset_valid_out", 72'(valid_out), 72'(0));
      chk("reset_frame_done", 72'(frame_done), 72'(0));
      chk("reset_window", window_out, 72'(0));
      last_win = '0;
    end else if (valid_out === 1'b1) begin
      nvalid++;
      if (frame_done === 1'b1) nfd++;
      got_q.push_back(window_out);
      chk("valid_after_accept", 72'(last_acc), 72'(1));
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got window %h expected no output (cycle %0d)", window_out, cyc);
      end else begin
        e = sbq.pop_front();
        chk("valid_cycle", 72'(cyc), 72'(e.cyc));
        chk("window", window_out, e.w);
        chk("frame_done", 72'(frame_done), 72'(e.fd));
      end
      last_win = window_out;
    end else begin
      chk("valid_out_low", 72'(valid_out), 72'(0));
      chk("frame_done_idle", 72'(frame_done), 72'(0));
      chk("window_hold", window_out, last_win);
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        checks++;
        fails++;
        $display("FAIL missing_window: got none expected %h at cycle %0d", e.w, e.cyc);
      end
    end
  end

  // Reference model: whole-frame image plus raster position
  logic [7:0] img [H][W];
  int mrow = 0;
  int mcol = 0;

  task automatic send(input logic [7:0] px);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    valid_in = 1'b1;
    pixel_in = px;
    img[mrow][mcol] = px;
    if (mrow >= 2 && mcol >= 2) begin
      e.w = '0;
      for (int ch = 0; ch < 8; ch++)
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < 3; k++)
            e.w[9*ch + 3*r + k] = img[mrow-2+r][mcol-2+k][ch];
      e.fd  = (mrow == H-1) && (mcol == W-1);
      e.cyc = cyc + 1;
      sbq.push_back(e);
    end
    if (mcol == W-1) begin
      mcol = 0;
      mrow = (mrow == H-1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst      = 1'b0;
      valid_in = 1'b0;
      pixel_in = 8'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst      = 1'b1;
      valid_in = ~valid_in;
      pixel_in = 8'($urandom);
    end
    mrow = 0;
    mcol = 0;
  endtask

  task automatic gap_rand();
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int f0;

    // Reset with valid_in toggling
    do_reset(2);
    idle(3);

    // Checkerboard on channel 0, continuous
    got_q.delete();
    n0 = nvalid;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send({7'b0, 1'(r + c)});
    idle(4);
    chk("checker_count", 72'(nvalid - n0), 72'(121));
    if (got_q.size() > 0) begin
      chk("checker_first_ch0", 72'(got_q[0][8:0]), 72'(9'h0AA));
      chk("checker_first_ch1_7", 72'(got_q[0][71:9]), 72'(0));
    end
    ref_q = got_q;

    // Same frame, valid every other cycle
    got_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send({7'b0, 1'(r + c)});
        idle(1);
      end
    idle(4);
    chk("gapped_count", 72'(got_q.size()), 72'(121));
    if (got_q.size() == ref_q.size())
      for (int i = 0; i < got_q.size(); i++)
        chk("gapped_order", got_q[i], ref_q[i]);

    // Back-to-back frames, pixel = frame parity
    got_q.delete();
    f0 = nfd;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W*H; i++)
        send((f == 0) ? 8'h00 : 8'hFF);
    idle(4);
    chk("b2b_frame_done_count", 72'(nfd - f0), 72'(2));
    chk("b2b_count", 72'(got_q.size()), 72'(242));
    if (got_q.size() == 242)
      for (int i = 121; i < 242; i++)
        chk("b2b_frame2_ones", got_q[i], {72{1'b1}});

    // Reset mid-frame after 50 random pixels, then a full random gapped frame
    for (int i = 0; i < 50; i++) begin
      send(8'($urandom));
      gap_rand();
    end
    idle(2);
    do_reset(1);
    idle(1);
    got_q.delete();
    for (int i = 0; i < W*H; i++) begin
      send(8'($urandom));
      gap_rand();
    end
    idle(4);
    chk("abort_count", 72'(got_q.size()), 72'(121));

    idle(4);
    chk("scoreboard_drained", 72'(sbq.size()), 72'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/conv_layer_2_window_buf.md
CONV_LAYER_2_WINDOW_BUF -- requirements
Module: conv_layer_2_window_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 13, pooled feature-map columns.
REQ-002 SHALL have parameter HEIGHT, default 13, pooled feature-map rows.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port valid_in, input, 1, pixel_in holds one pooled pixel for all 8 channels this cycle.
REQ-006 SHALL have port pixel_in, input, 8, bit i is the 1-bit channel i pooled pixel, from max-pool output i+1.
REQ-007 SHALL have port window_out, output, 72, 3x3 binary window per channel; channel c occupies bits [9c+8:9c].
REQ-008 SHALL have port valid_out, output, 1, window_out holds a complete valid window.
REQ-009 SHALL have port frame_done, output, 1, single-cycle pulse on the last window of a frame.

Function
REQ-010 SHALL treat the input as a raster-order stream: row 0 first, column 0 first within a row, WIDTH*HEIGHT pixels per frame.
REQ-011 SHALL keep a column counter (0..WIDTH-1) and a row counter (0..HEIGHT-1), both advancing only on valid_in=1.
REQ-012 SHALL wrap the column counter to 0 and increment the row counter after column WIDTH-1.
REQ-013 SHALL wrap both counters to 0 after pixel (HEIGHT-1, WIDTH-1), so the next pixel starts a new frame.
REQ-014 SHALL store the two previous rows for each channel in per-channel line buffers of WIDTH bits.
REQ-015 SHALL keep a 3-column shift window per channel.
REQ-016 SHALL leave counters, line buffers and window unchanged in any cycle with valid_in=0, so input gaps of any length are tolerated.
REQ-017 SHALL order each channel's taps row-major: bit 9c+3*r+k holds window row r (0 = oldest), column k (0 = leftmost).
REQ-018 SHALL make bit 9c+8 the pixel accepted this cycle.
REQ-019 SHALL register outputs with latency 1: a pixel accepted at (row, col) with row>=2 and col>=2 makes valid_out=1 in the next cycle.
REQ-020 SHALL, in that cycle, present on window_out rows row-2..row and columns col-2..col.
REQ-021 SHALL drive valid_out=0 in every other cycle, including the cycle after any valid_in=0 cycle and for col<2 or row<2.
REQ-022 SHALL produce exactly (WIDTH-2)*(HEIGHT-2) = 121 valid windows per frame at default parameters, WIDTH-2 per eligible row.
REQ-023 SHALL assert frame_done for one cycle, together with valid_out, for the window ending at pixel (HEIGHT-1, WIDTH-1).
REQ-024 SHALL hold window_out at its last value while valid_out=0; downstream samples it only when valid_out=1.
REQ-025 SHALL NOT clear line buffers between frames; the row>=2 gating excludes stale data.
REQ-026 SHALL have no backpressure input; downstream accepts every valid_out cycle.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set both counters to 0, valid_out=0, frame_done=0 and window_out=72'h0.
REQ-028 SHALL clear line buffers and window registers on reset; clearing is not relied upon functionally.
REQ-029 SHALL treat a reset mid-frame as an abort: the first valid_in after rst deasserts is pixel (0,0) of a new frame.
REQ-030 SHALL ignore valid_in during reset cycles.

Verification
REQ-031 Reset: hold rst=1 for 2 cycles with valid_in toggling -> valid_out=0, frame_done=0 and window_out=0 throughout and the cycle after.
REQ-032 Checkerboard frame, continuous valid_in for 169 cycles, channel 0 = (row+col)&1, other channels 0:
- exactly 121 valid_out pulses, the first one cycle after pixel index 28 (row 2, col 2);
- first channel-0 window = 9'h0AA; channels 1-7 windows = 0.
REQ-033 Same frame with valid_in=1 every other cycle -> same 121 windows in the same order; valid_out never high in the cycle after valid_in=0.
REQ-034 Edge exclusion:
- per row, no valid_out for pixels at col 0 and 1; rows 0-1 produce none;
- rows 2-12 produce exactly 11 each.
REQ-035 Back-to-back frames with no gap, pixel value = frame parity on all channels:
- frame_done high exactly twice, coincident with the 121st and 242nd valid_out;
- every frame-2 window = all ones on all channels, with no frame-1 data mixed in.
REQ-036 Reset mid-frame: assert rst after 50 pixels, then send a full frame -> 121 windows, contents matching a golden model that starts from (0,0).
